// File: rtl/prng_pkg.sv
// Shared types and constants for the range-limited LFSR sample generator.
package prng_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam logic [31:0] DEF_TAPS = 32'h8020_0003;
    localparam logic [31:0] DEF_SEED = 32'h9B34_6A37;

    // True when the low w bits of v are all ones (the XNOR-LFSR lock-up state).
    function automatic logic all_ones(input logic [63:0] v, input int w);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i < w && !v[i]) r = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/prng_range_gen_if.sv
// Sample delivery channel: producer drives valid/data, consumer drives ready.
interface prng_range_gen_if #(
    parameter int OUT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/prng_range_gen_lfsr_core.sv
// XNOR Fibonacci LFSR with step/load controls and all-ones lock-up recovery.
module lfsr_core
    import prng_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lock_evt;
    logic             fb;

    // Next state: a load wins, then lock-up recovery, then a normal shift.
    always_comb begin
        fb       = ~^(state_q & TAPS);
        state_d  = state_q;
        lock_evt = all_ones(64'(state_q), WIDTH);
        if (load_i) begin
            if (all_ones(64'(seed_i), WIDTH)) begin
                state_d  = SEED;
                lock_evt = 1'b1;
            end else begin
                state_d  = seed_i;
            end
        end else if (lock_evt) begin
            state_d = SEED;
        end else if (step_i) begin
            state_d = {state_q[WIDTH-2:0], fb};
        end
    end

    // State register and sticky lock-up flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SEED;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_q | lock_evt;
        end
    end

    assign state_o  = state_q;
    assign lockup_o = lockup_q;

endmodule

// File: rtl/prng_range_gen.sv
// Rejection-sampled signed random numbers in -RANGE_MAX..+RANGE_MAX over valid/ready.
module prng_range_gen
    import prng_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
    parameter int               OUT_W     = 8,
    parameter int               RANGE_MAX = 99,
    parameter int               CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     seed_load,
    input  logic [WIDTH-1:0]         seed_in,
    prng_range_gen_if.master         out_if,
    output logic [CNT_W-1:0]         reject_cnt,
    output logic                     lockup
);

    localparam int                      BCW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [BCW-1:0]          LAST = BCW'(OUT_W - 1);
    localparam logic signed [OUT_W-1:0] RMAX = OUT_W'(RANGE_MAX);
    localparam logic signed [OUT_W-1:0] RMIN = -RMAX;

    state_e                   st_q, st_d;
    logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                     valid_q, valid_d;
    logic [OUT_W-1:0]         data_q, data_d;
    logic [CNT_W-1:0]         rej_q, rej_d;
    logic                     step;
    logic [WIDTH-1:0]         lfsr_state;
    logic signed [OUT_W-1:0]  cand;
    logic                     in_range;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step_i   (step),
        .load_i   (seed_load),
        .seed_i   (seed_in),
        .state_o  (lfsr_state),
        .lockup_o (lockup)
    );

    // Candidate is the top OUT_W bits, which are all fresh after OUT_W shifts.
    assign cand     = lfsr_state[WIDTH-1 -: OUT_W];
    assign in_range = (cand >= RMIN) && (cand <= RMAX);

    // Draw FSM: fill OUT_W bits, check once, hold until the consumer takes it.
    always_comb begin
        st_d      = st_q;
        bit_cnt_d = bit_cnt_q;
        valid_d   = valid_q;
        data_d    = data_q;
        rej_d     = rej_q;
        step      = 1'b0;
        case (st_q)
            FILL: begin
                step = 1'b1;
                if (bit_cnt_q == LAST) begin
                    bit_cnt_d = '0;
                    st_d      = CHECK;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                if (in_range) begin
                    data_d  = cand;
                    valid_d = 1'b1;
                    st_d    = HOLD;
                end else begin
                    if (rej_q != '1) rej_d = rej_q + 1'b1;
                    bit_cnt_d = '0;
                    st_d      = FILL;
                end
            end
            HOLD: begin
                if (out_if.out_ready) begin
                    valid_d = 1'b0;
                    st_d    = FILL;
                end
            end
            default: st_d = FILL;
        endcase
        // Reseeding aborts any draw; a coincident handshake still completes.
        if (seed_load) begin
            st_d      = FILL;
            bit_cnt_d = '0;
            valid_d   = 1'b0;
            data_d    = data_q;
            rej_d     = rej_q;
            step      = 1'b0;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= FILL;
            bit_cnt_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            rej_q     <= '0;
        end else begin
            st_q      <= st_d;
            bit_cnt_q <= bit_cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            rej_q     <= rej_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign reject_cnt       = rej_q;

endmodule

// File: tb/tb_prng_range_gen.sv
// Directed bench: default 32-bit generator plus two 4-bit configurations.
module tb_prng_range_gen;

    logic        clk;
    logic        reset;
    logic        sl0;
    logic [31:0] si0;
    logic        sl_small;
    logic [3:0]  si_small;
    logic [15:0] rc0, rc1, rc2;
    logic        lk0, lk1, lk2;
    int          tests;
    int          fails;
    int          n;

    prng_range_gen_if #(.OUT_W(8)) if0 ();
    prng_range_gen_if #(.OUT_W(4)) if1 ();
    prng_range_gen_if #(.OUT_W(4)) if2 ();

    prng_range_gen dut0 (
        .clk(clk), .reset(reset), .seed_load(sl0), .seed_in(si0),
        .out_if(if0), .reject_cnt(rc0), .lockup(lk0)
    );

    prng_range_gen #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h0), .OUT_W(4), .RANGE_MAX(7), .CNT_W(16)
    ) dut1 (
        .clk(clk), .reset(reset), .seed_load(sl_small), .seed_in(si_small),
        .out_if(if1), .reject_cnt(rc1), .lockup(lk1)
    );

    prng_range_gen #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h0), .OUT_W(4), .RANGE_MAX(3), .CNT_W(16)
    ) dut2 (
        .clk(clk), .reset(reset), .seed_load(sl_small), .seed_in(si_small),
        .out_if(if2), .reject_cnt(rc2), .lockup(lk2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic vsel(input int s);
        case (s)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    // Counts edges until the selected generator presents a sample (bounded).
    task automatic wait_valid(input int s, input int maxc, output int cnt);
        cnt = 0;
        while (vsel(s) !== 1'b1 && cnt < maxc) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        clk = 0; reset = 1; sl0 = 0; si0 = '0; sl_small = 0; si_small = '0;
        if0.out_ready = 0; if1.out_ready = 0; if2.out_ready = 0;
        tick();
        chk("rst_valid", 32'(if0.out_valid), 0);
        chk("rst_data", 32'(if0.out_data), 0);
        chk("rst_rej", 32'(rc0), 0);
        chk("rst_lock", 32'(lk0), 0);

        // First sample: nothing for 8 edges, candidate 0x34 accepted at edge 9.
        reset = 0; if0.out_ready = 1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("lat1_valid", 32'(if0.out_valid), 0);
        end
        tick();
        chk("s1_valid", 32'(if0.out_valid), 1);
        chk("s1_data", 32'(if0.out_data), 52);
        chk("s1_rej", 32'(rc0), 0);
        tick();
        if0.out_ready = 0;
        chk("xfer_drop", 32'(if0.out_valid), 0);

        // Second: 0x6A (106) rejected, 0x37 (55) accepted -> 18 edges.
        wait_valid(0, 40, n);
        chk("s2_lat", 32'(n), 18);
        chk("s2_valid", 32'(if0.out_valid), 1);
        chk("s2_data", 32'(if0.out_data), 55);
        chk("s2_rej", 32'(rc0), 1);

        // Stall: data and valid hold for 20 cycles.
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("stall_valid", 32'(if0.out_valid), 1);
            chk("stall_data", 32'(if0.out_data), 55);
        end
        if0.out_ready = 1;
        tick();
        if0.out_ready = 0;

        // Third: 0x9C (-100) just outside range, then 0x59 (89).
        wait_valid(0, 40, n);
        chk("s3_lat", 32'(n), 18);
        chk("s3_data", 32'(if0.out_data), 89);
        chk("s3_rej", 32'(rc0), 2);

        // All-ones seed during FILL: recover to SEED, restart the sequence.
        if0.out_ready = 1;
        tick();
        if0.out_ready = 0;
        tick();
        tick();
        sl0 = 1; si0 = 32'hFFFF_FFFF;
        tick();
        sl0 = 0; si0 = '0;
        chk("sl_lock", 32'(lk0), 1);
        chk("sl_valid", 32'(if0.out_valid), 0);
        chk("sl_rej", 32'(rc0), 2);
        chk("sl_data", 32'(if0.out_data), 89);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("sl_lat_valid", 32'(if0.out_valid), 0);
        end
        tick();
        chk("sl_s1_valid", 32'(if0.out_valid), 1);
        chk("sl_s1_data", 32'(if0.out_data), 52);
        chk("sl_s1_rej", 32'(rc0), 2);
        chk("sl_lock_sticky", 32'(lk0), 1);

        // Reset in HOLD with a coincident ready: everything back to reset values.
        if0.out_ready = 1; reset = 1;
        tick();
        reset = 0; if0.out_ready = 0;
        chk("rh_valid", 32'(if0.out_valid), 0);
        chk("rh_data", 32'(if0.out_data), 0);
        chk("rh_rej", 32'(rc0), 0);
        chk("rh_lock", 32'(lk0), 0);
        wait_valid(0, 40, n);
        chk("rh_lat", 32'(n), 9);
        chk("rh_data1", 32'(if0.out_data), 52);

        // 4-bit, RANGE_MAX=7: -2 then -4, no rejections.
        chk("a_valid", 32'(if1.out_valid), 1);
        chk("a_s1", 32'(if1.out_data), 32'hE);
        chk("a_rej1", 32'(rc1), 0);
        if1.out_ready = 1;
        tick();
        if1.out_ready = 0;
        wait_valid(1, 40, n);
        chk("a_lat2", 32'(n), 5);
        chk("a_s2", 32'(if1.out_data), 32'hC);
        chk("a_rej2", 32'(rc1), 0);

        // 4-bit, RANGE_MAX=3: -2, then -4 and -6 rejected, then 1.
        chk("b_valid", 32'(if2.out_valid), 1);
        chk("b_s1", 32'(if2.out_data), 32'hE);
        chk("b_rej1", 32'(rc2), 0);
        if2.out_ready = 1;
        tick();
        if2.out_ready = 0;
        wait_valid(2, 40, n);
        chk("b_lat2", 32'(n), 15);
        chk("b_s2", 32'(if2.out_data), 32'h1);
        chk("b_rej2", 32'(rc2), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
